// File: rtl/fetch_unit.sv
// fetch_unit: program counter, imem request/response handshake and an
// in-order instruction FIFO for the decoder; redirects flush and kill.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_addr,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [31:0] pc, pc_nxt;

  logic [31:0] fq_inst [DEPTH];
  logic [31:0] fq_addr [DEPTH];
  logic [31:0] aq_addr [DEPTH];

  logic [PW-1:0] f_wr, f_rd;
  logic [PW-1:0] a_wr, a_rd;

  logic [CW-1:0] f_cnt, f_cnt_nxt;
  logic [CW-1:0] out_cnt, out_cnt_nxt;
  logic [CW-1:0] kill_cnt, kill_cnt_nxt;

  logic acc, rsp, redir, push, pop;
  logic unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc[1:0];

  // Credit: outstanding plus buffered may never exceed the FIFO depth
  assign imem_req  = (state == RUN) &&
                     (({1'b0, out_cnt} + {1'b0, f_cnt}) < LIMIT);
  assign imem_addr = pc;

  assign inst_valid = (f_cnt != '0);
  assign inst       = inst_valid ? fq_inst[f_rd] : 32'h0000_0013;
  assign inst_addr  = inst_valid ? fq_addr[f_rd] : 32'h0;

  assign acc   = imem_req & imem_ready;
  assign rsp   = imem_rvalid & (out_cnt != '0);
  assign redir = redirect_valid & (state != BOOT);
  assign push  = rsp & (kill_cnt == '0) & ~redir;
  assign pop   = inst_valid & inst_ready & ~redir;

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    out_cnt_nxt  = out_cnt + CW'(acc) - CW'(rsp);
    kill_cnt_nxt = kill_cnt;
    f_cnt_nxt    = f_cnt + CW'(push) - CW'(pop);
    if (rsp && (kill_cnt != '0))
      kill_cnt_nxt = kill_cnt - CW'(1);
    if (acc)
      pc_nxt = pc + 32'd4;
    unique case (state)
      BOOT: state_nxt = RUN;
      RUN, DRAIN: begin
        // Everything still in flight after a redirect is stale
        if (redir) begin
          pc_nxt       = {redirect_pc[31:2], 2'b00};
          kill_cnt_nxt = out_cnt_nxt;
          f_cnt_nxt    = '0;
        end
        state_nxt = (kill_cnt_nxt != '0) ? DRAIN : RUN;
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      out_cnt  <= '0;
      kill_cnt <= '0;
      f_cnt    <= '0;
      f_wr     <= '0;
      f_rd     <= '0;
      a_wr     <= '0;
      a_rd     <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      out_cnt  <= out_cnt_nxt;
      kill_cnt <= kill_cnt_nxt;
      f_cnt    <= f_cnt_nxt;
      if (acc)
        a_wr <= a_wr + PW'(1);
      if (rsp)
        a_rd <= a_rd + PW'(1);
      if (redir) begin
        f_wr <= '0;
        f_rd <= '0;
      end else begin
        if (push)
          f_wr <= f_wr + PW'(1);
        if (pop)
          f_rd <= f_rd + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acc)
      aq_addr[a_wr] <= pc;
    if (push) begin
      fq_inst[f_wr] <= imem_rdata;
      fq_addr[f_wr] <= aq_addr[a_rd];
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus, bench memory and a queue-based model
// of the fetch stage compared against the DUT every cycle.
module tb_fetch_unit;

  localparam int DEPTH = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_inst;
  logic [31:0] w_iaddr;

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_addr      (inst_addr),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_wrap (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (w_req),
    .imem_addr      (w_addr),
    .imem_ready     (1'b1),
    .imem_rvalid    (1'b0),
    .imem_rdata     (32'h0),
    .inst_valid     (w_valid),
    .inst           (w_inst),
    .inst_addr      (w_iaddr),
    .inst_ready     (1'b0),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0010_0093;
    if (a == 32'h4) return 32'h0020_0113;
    return {a[23:0], 8'h13} ^ 32'h5a00_0000;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Bench memory: fixed latency, in-order responses
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];
  int mem_lat = 1;
  bit mem_ready_en = 1'b1;

  initial begin
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) mq.delete();
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mq[0].addr);
        void'(mq.pop_front());
      end
      imem_ready = mem_ready_en;
      @(negedge clk);
      if (!rst_n) mq.delete();
      else if (imem_req && imem_ready)
        mq.push_back('{imem_addr, cyc + mem_lat});
    end
  end

  // Reference model: queues of in-flight requests and buffered words
  typedef struct {
    logic [31:0] addr;
    bit          killed;
  } ost_t;
  typedef struct {
    logic [31:0] w;
    logic [31:0] a;
  } ent_t;
  ost_t oq[$];
  ent_t fq[$];
  logic [31:0] m_pc;
  bit m_boot;

  function automatic bit draining();
    foreach (oq[i])
      if (oq[i].killed) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    logic exp_req, acc, rsp, redir;
    ost_t o;
    m_pc = RST_PC;
    m_boot = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_pc = RST_PC;
        m_boot = 1'b1;
        oq.delete();
        fq.delete();
      end
      exp_req = !m_boot && !draining() &&
                ((oq.size() + fq.size()) < DEPTH);
      chk("m_imem_req", imem_req, exp_req);
      chk("m_imem_addr", imem_addr, m_pc);
      chk("m_inst_valid", inst_valid, fq.size() > 0);
      chk("m_inst", inst, fq.size() > 0 ? fq[0].w : 32'h13);
      chk("m_inst_addr", inst_addr, fq.size() > 0 ? fq[0].a : 32'h0);
      if (rst_n) begin
        acc   = exp_req && imem_ready;
        rsp   = imem_rvalid && (oq.size() > 0);
        redir = redirect_valid && !m_boot;
        if (!redir && fq.size() > 0 && inst_ready)
          void'(fq.pop_front());
        if (rsp) begin
          o = oq.pop_front();
          if (!o.killed && !redir)
            fq.push_back('{imem_rdata, o.addr});
        end
        if (acc) begin
          oq.push_back('{m_pc, 1'b0});
          m_pc += 32'd4;
        end
        if (redir) begin
          fq.delete();
          foreach (oq[i]) oq[i].killed = 1'b1;
          m_pc = {redirect_pc[31:2], 2'b00};
        end
        m_boot = 1'b0;
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    nxt();
    nxt();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string nm, input logic [31:0] a,
                            input logic [31:0] w);
    int n;
    n = 0;
    while (!inst_valid && n < 20) begin
      nxt();
      n++;
    end
    if (!inst_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got no inst_valid want inst_valid", nm);
    end else begin
      chk({nm, "_iaddr"}, inst_addr, a);
      chk({nm, "_inst"}, inst, w);
    end
  endtask

  initial begin
    int n_acc;
    rst_n          = 1'b0;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_inst", inst, 32'h13);
    chk("rst_iaddr", inst_addr, 32'h0);
    chk("wrap_rst_addr", w_addr, 32'hFFFF_FFF8);

    // Basic stream, 1-cycle memory
    rst_n = 1'b1;
    #1;
    chk("boot_req", imem_req, 0);
    nxt();
    chk("c1_req", imem_req, 1);
    chk("c1_addr", imem_addr, 32'h0);
    chk("wrap_c1_req", w_req, 1);
    chk("wrap_c1_addr", w_addr, 32'hFFFF_FFF8);
    nxt();
    chk("c2_addr", imem_addr, 32'h4);
    chk("wrap_c2_addr", w_addr, 32'hFFFF_FFFC);
    nxt();
    chk("c3_valid", inst_valid, 1);
    chk("c3_inst", inst, 32'h0010_0093);
    chk("c3_iaddr", inst_addr, 32'h0);
    chk("wrap_c3_addr", w_addr, 32'h0);
    chk("wrap_c3_req", w_req, 0);
    nxt();
    chk("c4_inst", inst, 32'h0020_0113);
    chk("c4_iaddr", inst_addr, 32'h4);
    chk("c4_addr", imem_addr, 32'h8);
    repeat (8) nxt();

    // Backpressure
    inst_ready = 1'b0;
    rst_pulse();
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      nxt();
      if (imem_req && imem_ready) n_acc++;
    end
    chk("bp_accepts", n_acc, 2);
    chk("bp_req_off", imem_req, 0);
    chk("bp_head", inst_addr, 32'h0);
    inst_ready = 1'b1;
    nxt();
    chk("bp_second", inst_addr, 32'h4);
    chk("bp_resume_req", imem_req, 1);
    chk("bp_resume_addr", imem_addr, 32'h8);
    repeat (4) nxt();

    // Redirect with two stale responses in flight
    mem_lat = 3;
    rst_pulse();
    nxt();
    nxt();
    nxt();
    chk("r3_req_full", imem_req, 0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    nxt();
    redirect_valid = 1'b0;
    chk("r3_pc", imem_addr, 32'h100);
    chk("r3_drain_req", imem_req, 0);
    chk("r3_valid", inst_valid, 0);
    nxt();
    chk("r3_drop_valid", inst_valid, 0);
    nxt();
    chk("r3_run_req", imem_req, 1);
    chk("r3_run_addr", imem_addr, 32'h100);
    wait_valid("r3_first", 32'h100, 32'h5a01_0013);
    repeat (6) nxt();

    // Redirect coinciding with accept and response
    mem_lat = 1;
    rst_pulse();
    nxt();
    nxt();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    nxt();
    redirect_valid = 1'b0;
    chk("r4_valid", inst_valid, 0);
    chk("r4_drain_req", imem_req, 0);
    nxt();
    chk("r4_run_req", imem_req, 1);
    chk("r4_run_addr", imem_addr, 32'h200);
    wait_valid("r4_first", 32'h200, 32'h5a02_0013);
    repeat (6) nxt();

    // Redirect with nothing in flight, FIFO full
    inst_ready = 1'b0;
    rst_pulse();
    repeat (6) nxt();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0043;
    nxt();
    redirect_valid = 1'b0;
    chk("r5_valid", inst_valid, 0);
    chk("r5_req", imem_req, 1);
    chk("r5_addr", imem_addr, 32'h40);
    inst_ready = 1'b1;
    wait_valid("r5_first", 32'h40, 32'h5a00_4013);
    repeat (4) nxt();

    // Asynchronous reset with two buffered words
    inst_ready = 1'b0;
    rst_pulse();
    repeat (6) nxt();
    chk("ar_pre_valid", inst_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("ar_valid", inst_valid, 0);
    chk("ar_inst", inst, 32'h13);
    chk("ar_iaddr", inst_addr, 32'h0);
    chk("ar_req", imem_req, 0);
    nxt();
    nxt();
    rst_n = 1'b1;
    repeat (3) nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
